// File: rtl/fpu_arbiter_if.sv
// Requester/fpu/response bundle of fpu_arbiter.
// slave = arbiter view, master = requesters + fpu + response sink view.
interface fpu_arbiter_if #(
  parameter int unsigned NUM_REQ = 4
);
  localparam int unsigned ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]    req_valid_i;
  logic [NUM_REQ-1:0]    req_ready_o;
  logic [4*NUM_REQ-1:0]  req_mode_i;
  logic [16*NUM_REQ-1:0] req_in1_i;
  logic [16*NUM_REQ-1:0] req_in2_i;
  logic [3:0]            fpu_mode_o;
  logic [15:0]           fpu_in1_o;
  logic [15:0]           fpu_in2_o;
  logic [15:0]           fpu_out_i;
  logic                  fpu_overflow_i;
  logic                  rsp_valid_o;
  logic                  rsp_ready_i;
  logic [ID_W-1:0]       rsp_id_o;
  logic [15:0]           rsp_data_o;
  logic                  rsp_overflow_o;
  logic                  rsp_err_o;

  modport slave (
    input  req_valid_i, req_mode_i, req_in1_i, req_in2_i,
    input  fpu_out_i, fpu_overflow_i, rsp_ready_i,
    output req_ready_o, fpu_mode_o, fpu_in1_o, fpu_in2_o,
    output rsp_valid_o, rsp_id_o, rsp_data_o, rsp_overflow_o, rsp_err_o
  );

  modport master (
    output req_valid_i, req_mode_i, req_in1_i, req_in2_i,
    output fpu_out_i, fpu_overflow_i, rsp_ready_i,
    input  req_ready_o, fpu_mode_o, fpu_in1_o, fpu_in2_o,
    input  rsp_valid_o, rsp_id_o, rsp_data_o, rsp_overflow_o, rsp_err_o
  );
endinterface

// File: rtl/fpu_arbiter.sv
// Round-robin arbiter sharing one bfloat16 fpu among NUM_REQ requesters.
// Optional FPU_ARB_MODE_CHECK_EN: non-one-hot modes answered with qNaN + rsp_err_o.
module fpu_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned FPU_LAT = 1
) (
  input logic          clk,
  input logic          rst,
  fpu_arbiter_if.slave io_bus
);
  localparam int unsigned ID_W  = $clog2(NUM_REQ);
  localparam int unsigned IDX_W = ID_W + 1;
  localparam int unsigned CNT_W = (FPU_LAT > 0) ? $clog2(FPU_LAT + 1) : 1;
  localparam logic [15:0] QNAN  = 16'h7FC0;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

  state_t           r_state, w_state_nxt;
  logic [ID_W-1:0]  r_rr_ptr, w_grant, w_ptr_nxt;
  logic [IDX_W-1:0] w_idx;
  logic             w_found, w_illegal, w_accept, w_exec_done;
  logic [3:0]       w_sel_mode;
  logic [15:0]      w_sel_in1, w_sel_in2;
  logic [CNT_W-1:0] r_cnt;
  logic [3:0]       r_fpu_mode;
  logic [15:0]      r_fpu_in1, r_fpu_in2;
  logic             r_rsp_valid, r_rsp_ovf, r_rsp_err;
  logic [ID_W-1:0]  r_rsp_id;
  logic [15:0]      r_rsp_data;

  // First valid requester scanning upward from r_rr_ptr with wrap
  always_comb begin
    w_found = 1'b0;
    w_grant = '0;
    w_idx   = '0;
    for (int k = 0; k < int'(NUM_REQ); k++) begin
      w_idx = IDX_W'(r_rr_ptr) + IDX_W'(k);
      if (w_idx >= IDX_W'(NUM_REQ)) w_idx = w_idx - IDX_W'(NUM_REQ);
      if (!w_found && io_bus.req_valid_i[w_idx[ID_W-1:0]]) begin
        w_found = 1'b1;
        w_grant = w_idx[ID_W-1:0];
      end
    end
  end

  assign w_sel_mode = io_bus.req_mode_i[int'(w_grant)*4 +: 4];
  assign w_sel_in1  = io_bus.req_in1_i[int'(w_grant)*16 +: 16];
  assign w_sel_in2  = io_bus.req_in2_i[int'(w_grant)*16 +: 16];
  assign w_ptr_nxt  = (w_grant == ID_W'(NUM_REQ - 1)) ? '0 : w_grant + ID_W'(1);

`ifdef FPU_ARB_MODE_CHECK_EN
  assign w_illegal = !$onehot(w_sel_mode);
`else
  assign w_illegal = 1'b0;
`endif

  assign w_accept    = (r_state == S_IDLE) && w_found;
  assign w_exec_done = (r_state == S_EXEC) && (r_cnt == CNT_W'(FPU_LAT));

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_nxt = w_illegal ? S_RESP : S_EXEC;
      S_EXEC:  if (w_exec_done) w_state_nxt = S_RESP;
      S_RESP:  if (io_bus.rsp_ready_i) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // fpu pins double as the operand latch: loaded at accept, cleared on leaving EXEC
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr_ptr    <= '0;
      r_cnt       <= '0;
      r_fpu_mode  <= 4'h0;
      r_fpu_in1   <= 16'h0000;
      r_fpu_in2   <= 16'h0000;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
      r_rsp_data  <= 16'h0000;
      r_rsp_ovf   <= 1'b0;
      r_rsp_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_rr_ptr <= w_ptr_nxt;
            r_rsp_id <= w_grant;
            r_cnt    <= '0;
            if (w_illegal) begin
              r_rsp_valid <= 1'b1;
              r_rsp_data  <= QNAN;
              r_rsp_ovf   <= 1'b0;
              r_rsp_err   <= 1'b1;
            end else begin
              r_fpu_mode <= w_sel_mode;
              r_fpu_in1  <= w_sel_in1;
              r_fpu_in2  <= w_sel_in2;
            end
          end
        end
        S_EXEC: begin
          if (w_exec_done) begin
            r_rsp_valid <= 1'b1;
            r_rsp_data  <= io_bus.fpu_out_i;
            r_rsp_ovf   <= io_bus.fpu_overflow_i;
            r_rsp_err   <= 1'b0;
            r_fpu_mode  <= 4'h0;
            r_fpu_in1   <= 16'h0000;
            r_fpu_in2   <= 16'h0000;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_RESP: if (io_bus.rsp_ready_i) r_rsp_valid <= 1'b0;
        default: ;
      endcase
    end
  end

  // Accept strobe is combinational so a requester can handshake in its first valid cycle
  assign io_bus.req_ready_o    = (w_accept && !rst) ? (NUM_REQ'(1) << w_grant) : '0;
  assign io_bus.fpu_mode_o     = r_fpu_mode;
  assign io_bus.fpu_in1_o      = r_fpu_in1;
  assign io_bus.fpu_in2_o      = r_fpu_in2;
  assign io_bus.rsp_valid_o    = r_rsp_valid;
  assign io_bus.rsp_id_o       = r_rsp_id;
  assign io_bus.rsp_data_o     = r_rsp_data;
  assign io_bus.rsp_overflow_o = r_rsp_ovf;
  assign io_bus.rsp_err_o      = r_rsp_err;
endmodule

// File: tb/tb_fpu_arbiter.sv
// Bench for fpu_arbiter: directed scenarios plus random traffic against a
// transaction-level reference model; a behavioural bf16 fpu sits on the fpu pins.
module tb_fpu_arbiter;
  localparam int N   = 4;
  localparam int LAT = 1;
`ifdef FPU_ARB_MODE_CHECK_EN
  localparam bit MODE_CHECK = 1'b1;
`else
  localparam bit MODE_CHECK = 1'b0;
`endif
  localparam logic [3:0] ADD = 4'b0001, SUB = 4'b0010, MUL = 4'b0100, DIV = 4'b1000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fpu_arbiter_if #(.NUM_REQ(N)) bus();
  fpu_arbiter #(.NUM_REQ(N), .FPU_LAT(LAT)) dut (.clk(clk), .rst(rst), .io_bus(bus));

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_on = 1'b0;
  int acc_q[$];

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // bfloat16 arithmetic via double precision, truncating, flush-to-zero
  function automatic real bf2r(input logic [15:0] v);
    if (v[14:7] == 8'd0) return 0.0;
    return $bitstoreal({v[15], 11'(v[14:7]) + 11'd896, v[6:0], 45'd0});
  endfunction

  function automatic logic [16:0] r2bf(input real r);
    logic [63:0] d;
    int e;
    d = $realtobits(r);
    if (d[62:0] == 63'd0) return 17'h0;
    e = int'(d[62:52]) - 896;
    if (e >= 255) return {1'b1, d[63], 8'hFF, 7'h0};
    if (e <= 0) return {1'b0, d[63], 15'h0};
    return {1'b0, d[63], 8'(e), d[51:45]};
  endfunction

  function automatic logic [16:0] bf16_op(input logic [3:0] m, input logic [15:0] a, input logic [15:0] b);
    real x, y;
    x = bf2r(a);
    y = bf2r(b);
    case (m)
      ADD: return r2bf(x + y);
      SUB: return r2bf(x - y);
      MUL: return r2bf(x * y);
      DIV: return (y == 0.0) ? 17'h0 : r2bf(x / y);
      default: return 17'h0;
    endcase
  endfunction

  // fpu with one register stage
  logic [16:0] fpu_q;
  always @(posedge clk) fpu_q <= bf16_op(bus.fpu_mode_o, bus.fpu_in1_o, bus.fpu_in2_o);
  assign bus.fpu_out_i      = fpu_q[15:0];
  assign bus.fpu_overflow_i = fpu_q[16];

  // Reference model: phase 0 idle, 1 executing, 2 responding
  int          m_phase = 0, m_cnt = 0, m_ptr = 0, m_id = 0, mg;
  logic [3:0]  m_mode = 4'h0;
  logic [15:0] m_a = 16'h0, m_b = 16'h0, m_data = 16'h0;
  logic        m_ovf = 1'b0, m_err = 1'b0;
  logic [16:0] m_res;

  function automatic int exp_grant();
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = (m_ptr + k) % N;
      if (bus.req_valid_i[idx]) return idx;
    end
    return -1;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_phase = 0;
      m_ptr   = 0;
    end else begin
      case (m_phase)
        0: begin
          mg = exp_grant();
          if (mg >= 0) begin
            m_id   = mg;
            m_mode = bus.req_mode_i[4*mg +: 4];
            m_a    = bus.req_in1_i[16*mg +: 16];
            m_b    = bus.req_in2_i[16*mg +: 16];
            m_ptr  = (mg + 1) % N;
            if (MODE_CHECK && $countones(m_mode) != 1) begin
              m_phase = 2; m_data = 16'h7FC0; m_ovf = 1'b0; m_err = 1'b1;
            end else begin
              m_phase = 1; m_cnt = LAT + 1;
            end
          end
        end
        1: begin
          m_cnt--;
          if (m_cnt == 0) begin
            m_res   = bf16_op(m_mode, m_a, m_b);
            m_phase = 2; m_data = m_res[15:0]; m_ovf = m_res[16]; m_err = 1'b0;
          end
        end
        default: if (bus.rsp_ready_i) m_phase = 0;
      endcase
    end
  end

  int         mon_g;
  logic [3:0] mon_er;
  always @(negedge clk) begin
    if (chk_on) begin
      mon_g  = exp_grant();
      mon_er = (m_phase == 0 && !rst && mon_g >= 0) ? 4'(1 << mon_g) : 4'h0;
      chk_eq("req_ready", 32'(bus.req_ready_o), 32'(mon_er));
      chk_eq("rsp_valid", 32'(bus.rsp_valid_o), 32'(m_phase == 2));
      chk_eq("fpu_mode", 32'(bus.fpu_mode_o), 32'(m_phase == 1 ? m_mode : 4'h0));
      chk_eq("fpu_in1", 32'(bus.fpu_in1_o), 32'(m_phase == 1 ? m_a : 16'h0));
      chk_eq("fpu_in2", 32'(bus.fpu_in2_o), 32'(m_phase == 1 ? m_b : 16'h0));
      if (m_phase == 2) begin
        chk_eq("rsp_id", 32'(bus.rsp_id_o), 32'(m_id));
        chk_eq("rsp_data", 32'(bus.rsp_data_o), 32'(m_data));
        chk_eq("rsp_ovf", 32'(bus.rsp_overflow_o), 32'(m_ovf));
        chk_eq("rsp_err", 32'(bus.rsp_err_o), 32'(m_err));
      end
      if (!rst) for (int i = 0; i < N; i++)
        if (bus.req_ready_o[i] && bus.req_valid_i[i]) acc_q.push_back(i);
    end
  end

  task automatic set_req(input int i, input logic v, input logic [3:0] m,
                         input logic [15:0] a, input logic [15:0] b);
    bus.req_valid_i[i]       = v;
    bus.req_mode_i[4*i +: 4]  = m;
    bus.req_in1_i[16*i +: 16] = a;
    bus.req_in2_i[16*i +: 16] = b;
  endtask

  function automatic logic [15:0] rnd_op();
    return {1'($urandom), 8'($urandom_range(110, 144)), 7'($urandom)};
  endfunction

  function automatic logic [3:0] rnd_mode();
    int r;
    r = int'($urandom_range(0, 9));
    if (r < 8) return 4'(1 << (r % 4));
    return 4'($urandom);
  endfunction

  logic [16:0] exp5;
  int t;

  initial begin
    bus.req_valid_i = '1;
    bus.req_mode_i  = '0;
    bus.req_in1_i   = '0;
    bus.req_in2_i   = '0;
    bus.rsp_ready_i = 1'b1;
    repeat (3) @(posedge clk);
    #1 chk_on = 1'b1;
    @(negedge clk);
    chk_eq("rst_ready", 32'(bus.req_ready_o), 32'h0);
    chk_eq("rst_valid", 32'(bus.rsp_valid_o), 32'h0);
    chk_eq("rst_id", 32'(bus.rsp_id_o), 32'h0);
    chk_eq("rst_data", 32'(bus.rsp_data_o), 32'h0);
    chk_eq("rst_err", 32'(bus.rsp_err_o), 32'h0);
    chk_eq("rst_fpu_mode", 32'(bus.fpu_mode_o), 32'h0);
    @(posedge clk); #1 rst = 1'b0; bus.req_valid_i = '0;

    // 1: single ADD, fixed latency, one-cycle response
    set_req(0, 1'b1, ADD, 16'h3F80, 16'h4000);
    @(negedge clk) chk_eq("t1_ready", 32'(bus.req_ready_o), 32'h1);
    @(posedge clk); #1 set_req(0, 1'b0, ADD, 16'h3F80, 16'h4000);
    repeat (2) begin @(negedge clk) chk_eq("t1_early", 32'(bus.rsp_valid_o), 32'h0); end
    @(negedge clk);
    chk_eq("t1_valid", 32'(bus.rsp_valid_o), 32'h1);
    chk_eq("t1_id", 32'(bus.rsp_id_o), 32'h0);
    chk_eq("t1_data", 32'(bus.rsp_data_o), 32'h4040);
    chk_eq("t1_ovf", 32'(bus.rsp_overflow_o), 32'h0);
    @(negedge clk) chk_eq("t1_drop", 32'(bus.rsp_valid_o), 32'h0);

    // 2: all requesters held valid -> strict rotation
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    for (int i = 0; i < N; i++) set_req(i, 1'b1, MUL, 16'h4000, 16'h4000);
    acc_q.delete();
    t = 0;
    while (acc_q.size() < 8 && t < 200) begin
      @(negedge clk); t++;
      if (bus.rsp_valid_o) chk_eq("t2_data", 32'(bus.rsp_data_o), 32'h4080);
    end
    @(posedge clk); #1 bus.req_valid_i = '0;
    chk_eq("t2_count", 32'(acc_q.size()), 32'd8);
    for (int k = 0; k < 8 && k < acc_q.size(); k++) chk_eq("t2_order", 32'(acc_q[k]), 32'(k % N));
    repeat (6) @(posedge clk);

    // 3: response back-pressure, no accept while busy
    #1 bus.rsp_ready_i = 1'b0;
    set_req(2, 1'b1, SUB, 16'h4040, 16'h3F80);
    @(negedge clk) chk_eq("t3_ready", 32'(bus.req_ready_o), 32'h4);
    @(posedge clk); #1 set_req(2, 1'b0, SUB, 16'h0, 16'h0);
    set_req(1, 1'b1, ADD, 16'h3F80, 16'h3F80);
    repeat (2) @(negedge clk);
    repeat (5) begin
      @(negedge clk);
      chk_eq("t3_valid", 32'(bus.rsp_valid_o), 32'h1);
      chk_eq("t3_id", 32'(bus.rsp_id_o), 32'h2);
      chk_eq("t3_data", 32'(bus.rsp_data_o), 32'h4000);
      chk_eq("t3_busy", 32'(bus.req_ready_o), 32'h0);
    end
    @(posedge clk); #1 bus.rsp_ready_i = 1'b1;
    @(negedge clk) chk_eq("t3_hold", 32'(bus.rsp_valid_o), 32'h1);
    @(negedge clk);
    chk_eq("t3_done", 32'(bus.rsp_valid_o), 32'h0);
    chk_eq("t3_next", 32'(bus.req_ready_o), 32'h2);
    @(posedge clk); #1 set_req(1, 1'b0, ADD, 16'h0, 16'h0);
    repeat (5) @(posedge clk);

    // 4: reset during EXEC drops the op and rewinds the pointer
    #1 set_req(1, 1'b1, DIV, 16'h4000, 16'h3F80);
    @(negedge clk) chk_eq("t4_ready", 32'(bus.req_ready_o), 32'h2);
    @(posedge clk); #1 set_req(1, 1'b0, DIV, 16'h4000, 16'h3F80); rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    repeat (4) begin @(negedge clk) chk_eq("t4_no_rsp", 32'(bus.rsp_valid_o), 32'h0); end
    @(posedge clk); #1 set_req(1, 1'b1, DIV, 16'h4000, 16'h3F80);
    set_req(3, 1'b1, ADD, 16'h3F80, 16'h3F80);
    @(negedge clk) chk_eq("t4_rr0", 32'(bus.req_ready_o), 32'h2);
    @(posedge clk); #1 bus.req_valid_i = '0;
    repeat (5) @(posedge clk);

    // 5: overflow passthrough
    #1 set_req(3, 1'b1, MUL, 16'h7F7F, 16'h7F7F);
    exp5 = bf16_op(MUL, 16'h7F7F, 16'h7F7F);
    @(negedge clk) chk_eq("t5_ready", 32'(bus.req_ready_o), 32'h8);
    @(posedge clk); #1 bus.req_valid_i = '0;
    repeat (3) @(negedge clk);
    chk_eq("t5_ovf", 32'(bus.rsp_overflow_o), 32'h1);
    chk_eq("t5_id", 32'(bus.rsp_id_o), 32'h3);
    chk_eq("t5_data", 32'(bus.rsp_data_o), 32'(exp5[15:0]));
    repeat (3) @(posedge clk);

    // 6: non-one-hot mode
    #1 set_req(0, 1'b1, 4'b0011, 16'h3F80, 16'h4000);
    @(negedge clk) chk_eq("t6_ready", 32'(bus.req_ready_o), 32'h1);
    @(posedge clk); #1 bus.req_valid_i = '0;
`ifdef FPU_ARB_MODE_CHECK_EN
    @(negedge clk);
    chk_eq("t6_valid", 32'(bus.rsp_valid_o), 32'h1);
    chk_eq("t6_data", 32'(bus.rsp_data_o), 32'h7FC0);
    chk_eq("t6_err", 32'(bus.rsp_err_o), 32'h1);
    chk_eq("t6_fpu_mode", 32'(bus.fpu_mode_o), 32'h0);
`else
    repeat (2) begin @(negedge clk) chk_eq("t6_fpu_mode", 32'(bus.fpu_mode_o), 32'h3); end
    @(negedge clk);
    chk_eq("t6_valid", 32'(bus.rsp_valid_o), 32'h1);
    chk_eq("t6_err", 32'(bus.rsp_err_o), 32'h0);
`endif
    repeat (3) @(posedge clk);

    // Random traffic with back-pressure and occasional reset
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      rst = ($urandom_range(0, 299) == 0);
      bus.rsp_ready_i = ($urandom_range(0, 9) < 7);
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 2) == 0) set_req(i, 1'($urandom), rnd_mode(), rnd_op(), rnd_op());
    end
    @(posedge clk); #1 rst = 1'b0; bus.req_valid_i = '0; bus.rsp_ready_i = 1'b1;
    repeat (10) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
